// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
//   Shares one iterative shift-add 16x16 unsigned multiplier between two
//   requesters. Round-robin arbitration (1-bit last-grant pointer), one
//   partial-product step per MUL cycle, and the result is held in DONE
//   until the consumer accepts it.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   req0_valid/_a/_b/_ready  requester 0 handshake and operands
//   req1_valid/_a/_b/_ready  requester 1 handshake and operands
//   res_valid/_id/_p/_ready  result handshake, owner id, 32-bit product
//   busy                     high whenever the FSM is not IDLE
//
// Build option
//   MUL_EARLY_TERM_EN : when defined, MUL also exits as soon as the
//                       remaining multiplier bits are all zero.
module mul_share_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  output logic        res_id,
  output logic [31:0] res_p,
  input  logic        res_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;

  logic        grant;
  logic        accept;
  logic        last_iter;

  // Tie goes to the requester not served last; otherwise the lone requester.
  assign grant  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign accept = (state_q == S_IDLE) && (req0_valid || req1_valid);

  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this step's shift.
  assign last_iter = (cnt_q == 4'd15) || (mplier_q[15:1] == '0);
`else
  assign last_iter = (cnt_q == 4'd15);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d  = grant;
          last_d   = grant;
          acc_d    = '0;
          mcand_d  = {16'h0000, (grant ? req1_b : req0_b)};
          mplier_d = grant ? req1_a : req0_a;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_valid = (state_q == S_DONE);
  assign res_p     = res_valid ? acc_q : '0;
  assign res_id    = res_valid ? owner_q : 1'b0;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
module tb_mul_share_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id, res_ready, busy;
  logic [31:0] res_p;

  int n_checks = 0;
  int n_fail   = 0;

  mul_share_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_p      (res_p),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Expected cycle (acceptance edge = cycle 0) in which res_valid first rises.
  function automatic int exp_lat(input logic [15:0] a);
    int k;
`ifdef MUL_EARLY_TERM_EN
    k = 1;
    for (int i = 0; i < 16; i++) if (a[i]) k = i + 1;
    return k + 1;
`else
    k = a[0];
    return 17 + k - k;
`endif
  endfunction

  // Called at acceptance-edge+1 (cycle 1); returns cycle index where
  // res_valid is observed high, or -1 on timeout.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (res_valid !== 1'b1) cyc = -1;
  endtask

  // Present one request at a negedge, let the next posedge accept it,
  // then drop valid and scramble operands. Returns at cycle 1.
  task automatic accept_req(input logic id, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b0; req1_a = 16'hDEAD; req1_b = 16'hBEEF; end
    else    begin req0_valid = 1'b0; req0_a = 16'hDEAD; req0_b = 16'hBEEF; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({res_valid, res_id, busy, req0_ready, req1_ready} !== 5'b0 || res_p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual v=%b id=%b busy=%b r0=%b r1=%b p=%h required all 0",
               res_valid, res_id, busy, req0_ready, req1_ready, res_p);
    end
    // Lone requester 1 gets ready, combinationally
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lone_req1_ready: actual r0=%b r1=%b required r0=0 r1=1", req0_ready, req1_ready);
    end
    req1_valid = 1'b0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL no_valid_ready: actual r1=%b required 0", req1_ready);
    end
  endtask

  task automatic test_single();
    int cyc;
    rst = 1'b1;
    res_ready = 1'b1;
    #3;
    // Request presented as reset drops; first edge after deassert accepts it
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: actual r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    n_checks++;
    if (busy !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: actual busy=%b r0=%b required busy=1 r0=0", busy, req0_ready);
    end
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd3)) begin
      n_fail++;
      $display("FAIL single_latency: actual %0d required %0d", cyc, exp_lat(16'd3));
    end
    n_checks++;
    if (res_p !== 32'd15 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: actual p=%0d id=%b required p=15 id=0", res_p, res_id);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_p !== 32'h0) begin
      n_fail++;
      $display("FAIL single_release: actual v=%b busy=%b p=%h required 0 0 0", res_valid, busy, res_p);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd9;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_first: actual r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    // req0 stays valid with new operands so the pointer decides the next grant
    req0_a = 16'd3; req0_b = 16'd3;
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd2) || res_p !== 32'd14 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_res0: actual cyc=%0d p=%0d id=%b required cyc=%0d p=14 id=0",
               cyc, res_p, res_id, exp_lat(16'd2));
    end
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_no_ready: actual r0=%b r1=%b required 0 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_second: actual r0=%b r1=%b required r0=0 r1=1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0;
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd4) || res_p !== 32'd36 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_res1: actual cyc=%0d p=%0d id=%b required cyc=%0d p=36 id=1",
               cyc, res_p, res_id, exp_lat(16'd4));
    end
    @(posedge clk); #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waiting_req0: actual r0=%b required 1", req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_max_operands();
    int cyc;
    res_ready = 1'b1;
    accept_req(1'b0, 16'hFFFF, 16'hFFFF);
    wait_result(cyc);
    n_checks++;
    if (cyc !== 17 || res_p !== 32'hFFFE0001 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL max_operands: actual cyc=%0d p=%h id=%b required cyc=17 p=fffe0001 id=0",
               cyc, res_p, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    res_ready = 1'b0;
    accept_req(1'b0, 16'h1234, 16'h0056);
    req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd6;
    bad = 0;
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < 200) begin
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_ready_low: actual %0d cycles with ready high required 0", bad);
    end
    n_checks++;
    if (cyc !== exp_lat(16'h1234) || res_p !== 32'h00061D78 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_result: actual cyc=%0d p=%h id=%b required cyc=%0d p=00061d78 id=0",
               cyc, res_p, res_id, exp_lat(16'h1234));
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_p !== 32'h00061D78 || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: actual %0d unstable cycles required 0", bad);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || res_p !== 32'h0 || res_id !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: actual v=%b p=%h id=%b r1=%b required v=0 p=0 id=0 r1=1",
               res_valid, res_p, res_id, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd5) || res_p !== 32'd30 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pending_req1: actual cyc=%0d p=%0d id=%b required cyc=%0d p=30 id=1",
               cyc, res_p, res_id, exp_lat(16'd5));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int seen;
    res_ready = 1'b1;
    accept_req(1'b0, 16'hFFFF, 16'h0101);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({res_valid, res_id, busy, req0_ready, req1_ready} !== 5'b0 || res_p !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: actual v=%b id=%b busy=%b p=%h required all 0",
               res_valid, res_id, busy, res_p);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_aborted: actual %0d cycles with result/busy required 0", seen);
    end
    accept_req(1'b0, 16'd7, 16'd8);
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd7) || res_p !== 32'd56 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_next_req: actual cyc=%0d p=%0d id=%b required cyc=%0d p=56 id=0",
               cyc, res_p, res_id, exp_lat(16'd7));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short_operands();
    int cyc;
    res_ready = 1'b1;
    accept_req(1'b1, 16'd1, 16'd7);
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd1) || res_p !== 32'd7 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL a1_b7: actual cyc=%0d p=%0d id=%b required cyc=%0d p=7 id=1",
               cyc, res_p, res_id, exp_lat(16'd1));
    end
    @(posedge clk); #1;
    accept_req(1'b0, 16'd0, 16'h1234);
    wait_result(cyc);
    n_checks++;
    if (cyc !== exp_lat(16'd0) || res_p !== 32'd0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL a0_b1234: actual cyc=%0d p=%0d v=%b required cyc=%0d p=0 v=1",
               cyc, res_p, res_valid, exp_lat(16'd0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_backpressure();
    test_reset_mid_op();
    test_short_operands();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
REQ-002 Requester 0 ports SHALL be:
- req0_valid  in  1  request pending.
- req0_a  in  16  multiplier operand.
- req0_b  in  16  multiplicand operand.
- req0_ready  out  1  request accepted this cycle.
REQ-003 Requester 1 ports SHALL be:
- req1_valid  in  1  request pending.
- req1_a  in  16  multiplier operand.
- req1_b  in  16  multiplicand operand.
- req1_ready  out  1  request accepted this cycle.
REQ-004 Result and status ports SHALL be:
- res_valid  out  1  result available.
- res_id  out  1  index of the requester that owns the result.
- res_p  out  32  unsigned product a*b.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The block SHALL share one iterative shift-add 16x16 unsigned multiplier between two requesters.
REQ-006 The block SHALL use three states: IDLE, MUL and DONE.
REQ-007 In IDLE, reqN_ready SHALL be combinational and high only for the granted requester whose reqN_valid is high; at most one ready SHALL be high per cycle.
REQ-008 Arbitration SHALL be round-robin, using a 1-bit last-grant pointer:
- If both valids are high, grant the requester not granted last.
- If one valid is high, grant that requester.
REQ-009 On acceptance (valid and ready high at the same edge), the block SHALL perform all of the following:
- Capture a and b.
- Record the owner id.
- Update the last-grant pointer.
- Clear the 32-bit accumulator.
- Load the multiplicand zero-extended to 32 bits, and the multiplier.
- Enter MUL.
REQ-010 Each MUL cycle SHALL execute one step:
- If multiplier bit 0 is 1, add the multiplicand to the accumulator.
- Shift the multiplicand left by 1 and the multiplier right by 1.
- Increment a 4-bit iteration count.
REQ-011 MUL SHALL exit to DONE after the iteration with count 15, giving exactly 16 MUL cycles.
REQ-012 The accumulator SHALL be 32 bits and SHALL never overflow; 0xFFFF*0xFFFF SHALL yield 0xFFFE0001.
REQ-013 In DONE, the block SHALL drive res_valid=1, res_p=accumulator and res_id=owner.
REQ-014 The DONE outputs SHALL be held stable until res_ready is sampled high.
REQ-015 When res_valid and res_ready are both high at an edge, the block SHALL return to IDLE. A new request SHALL NOT be accepted in that same cycle; the earliest acceptance is the following cycle.
REQ-016 Latency SHALL be measured from the acceptance edge (cycle 0): MUL occupies cycles 1-16, and res_valid is first high in cycle 17.
REQ-017 Operand inputs SHALL be ignored outside the acceptance edge; requesters may change them after acceptance.
REQ-018 While a result is pending (MUL or DONE), both ready outputs SHALL be 0, and pending valids SHALL wait without loss.
REQ-019 When res_valid is 0, res_p and res_id SHALL be driven to 0.

Reset
REQ-020 Reset SHALL be asynchronous and active-high, and SHALL force the following values:
- state=IDLE.
- accumulator, operands and count = 0.
- res_valid=0, res_p=0, res_id=0, busy=0.
- last-grant pointer=1, so requester 0 wins the first tie.
REQ-021 Reset asserted during MUL or DONE SHALL abort the operation; no result for the aborted request SHALL ever appear.
REQ-022 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-023 The macro MUL_EARLY_TERM_EN SHALL control early termination as follows:
- Defined: MUL SHALL also exit to DONE after any iteration whose shifted multiplier is 0. Latency becomes k+1 cycles, where k = max(1, position of the highest set bit of a, plus 1).
- Undefined: latency SHALL be fixed at 17 cycles per REQ-016.
- In both cases, the product values SHALL be identical.

Verification
REQ-024 Single request: req0 a=3, b=5, res_ready=1 -> req0_ready at cycle 0; res_valid at cycle 17 with res_p=15 and res_id=0 (EN undefined).
REQ-025 Both requesters valid at the same edge after reset (a=2,b=7 and a=4,b=9) -> req0 served first (res_p=14, id 0); then req1 accepted one cycle after the result handshake (res_p=36, id 1).
REQ-026 Max operands: a=0xFFFF, b=0xFFFF -> res_p=0xFFFE0001 at cycle 17, in both macro configurations.
REQ-027 Backpressure: hold res_ready=0 for 5 cycles after res_valid rises -> res_valid, res_p and res_id stay constant, req0_ready and req1_ready stay 0, and the result completes when res_ready=1.
REQ-028 Reset mid-operation: assert rst in MUL cycle 8 -> all outputs 0 immediately; no res_valid follows; the next request completes normally.
REQ-029 Early termination with MUL_EARLY_TERM_EN defined: a=1, b=7 -> res_valid at cycle 2 with res_p=7; and a=0, b=0x1234 -> res_valid at cycle 2 with res_p=0.
